// File: rtl/cmd_frame_builder_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cmd_frame_builder_if                                                      |
// | Command handshake and byte-stream bundle for cmd_frame_builder.           |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface cmd_frame_builder_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_type;
  logic [3:0]       cmd_addr;
  logic [7:0]       cmd_data_a;
  logic [7:0]       cmd_data_b;
  logic [3:0]       cmd_fun;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
           byte_ready,
    input  cmd_ready, byte_out, byte_valid, busy, frame_done, frame_cnt
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
           byte_ready,
    output cmd_ready, byte_out, byte_valid, busy, frame_done, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cmd_frame_builder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cmd_frame_builder                                                         |
// | Expands one host command into the UART/ALU byte protocol, with gap.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module cmd_frame_builder #(
  parameter int GAP_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  cmd_frame_builder_if.slave bus
);

  localparam int              GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   C_GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [1:0]       r_type;
  logic [3:0]       r_addr;
  logic [7:0]       r_data_a;
  logic [7:0]       r_data_b;
  logic [3:0]       r_fun;
  logic [1:0]       r_idx;
  logic [1:0]       r_last_idx;
  logic [GW-1:0]    r_gap;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [7:0]       w_byte;

  logic w_accept;
  logic w_byte_hs;
  logic w_last_hs;

  assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
  assign w_byte_hs = (r_state == S_SEND) && bus.byte_ready;
  assign w_last_hs = w_byte_hs && (r_idx == r_last_idx);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_SEND;
      S_SEND:  if (w_last_hs) w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (r_gap == '0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command fields are frozen at acceptance; the index walks the captured frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_type       <= 2'd0;
      r_addr       <= 4'd0;
      r_data_a     <= 8'd0;
      r_data_b     <= 8'd0;
      r_fun        <= 4'd0;
      r_idx        <= 2'd0;
      r_last_idx   <= 2'd0;
      r_gap        <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= w_last_hs;
      if (w_accept) begin
        r_type   <= bus.cmd_type;
        r_addr   <= bus.cmd_addr;
        r_data_a <= bus.cmd_data_a;
        r_data_b <= bus.cmd_data_b;
        r_fun    <= bus.cmd_fun;
        r_idx    <= 2'd0;
        case (bus.cmd_type)
          2'd0:    r_last_idx <= 2'd2;
          2'd2:    r_last_idx <= 2'd3;
          default: r_last_idx <= 2'd1;
        endcase
      end
      if (w_byte_hs && !w_last_hs) r_idx <= r_idx + 2'd1;
      if (w_last_hs) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        r_gap       <= C_GAP_LOAD;
      end else if (r_state == S_GAP && r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      2'd0: begin
        case (r_type)
          2'd0:    w_byte = 8'hAA;
          2'd1:    w_byte = 8'hBB;
          2'd2:    w_byte = 8'hCC;
          default: w_byte = 8'hDD;
        endcase
      end
      2'd1: begin
        if (r_type == 2'd2)      w_byte = r_data_a;
        else if (r_type == 2'd3) w_byte = {4'h0, r_fun};
        else                     w_byte = {4'h0, r_addr};
      end
      2'd2:    w_byte = (r_type == 2'd0) ? r_data_a : r_data_b;
      default: w_byte = {4'h0, r_fun};
    endcase
  end

  always_comb begin
    bus.cmd_ready  = (r_state == S_IDLE);
    bus.busy       = (r_state != S_IDLE);
    bus.byte_valid = (r_state == S_SEND);
    bus.byte_out   = (r_state == S_SEND) ? w_byte : 8'h00;
    bus.frame_done = r_frame_done;
    bus.frame_cnt  = r_frame_cnt;
  end

endmodule
`default_nettype wire
